// File: rtl/c3_heap_pkg.sv
// Shared encodings for the C3 binary min-heap sequencer.
package c3_heap_pkg;

  localparam int unsigned RD_W  = 5;
  localparam int unsigned VRD_W = 3;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [OP_W-1:0] {
    HEAP_PUSH  = 2'd0,
    HEAP_POP   = 2'd1,
    HEAP_PEEK  = 2'd2,
    HEAP_CLEAR = 2'd3
  } heap_op_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_UP_RD   = 4'd1,
    S_UP_CMP  = 4'd2,
    S_POP_RD0 = 4'd3,
    S_POP_RDL = 4'd4,
    S_DN_RDL  = 4'd5,
    S_DN_RDR  = 4'd6,
    S_DN_CMP  = 4'd7,
    S_WR_FIN  = 4'd8,
    S_RESP    = 4'd9
  } heap_state_e;

endpackage

// File: rtl/c3_heap_sequencer.sv
// Min-heap command sequencer: drives sift-up/sift-down walks over an external
// single-port RAM with 1-cycle read latency and answers one command at a time.
module c3_heap_sequencer
  import c3_heap_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_v,
  output logic              cmd_rdy,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [RD_W-1:0]   cmd_rd,
  input  logic [VRD_W-1:0]  cmd_vrd1,
  input  logic [VRD_W-1:0]  cmd_vrd2,
  output logic              rsp_v,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [RD_W-1:0]   rsp_rd,
  output logic [VRD_W-1:0]  rsp_vrd1,
  output logic [VRD_W-1:0]  rsp_vrd2,
  output logic [ADDR_W:0]   heap_size,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SZ_W = ADDR_W + 1;

  heap_state_e       r_state;
  heap_op_e          r_op;
  logic [SZ_W-1:0]   r_size;
  logic [SZ_W-1:0]   r_hole;
  logic [DATA_W-1:0] r_cur;
  logic              r_cur_pend;
  logic [DATA_W-1:0] r_lval;
  logic              r_cmd_rdy;
  logic              r_rsp_v;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data;
  logic [RD_W-1:0]   r_rsp_rd;
  logic [VRD_W-1:0]  r_rsp_vrd1;
  logic [VRD_W-1:0]  r_rsp_vrd2;

  logic [DATA_W-1:0] w_cur;
  logic [SZ_W-1:0]   w_par;
  logic [SZ_W-1:0]   w_l;
  logic [SZ_W-1:0]   w_r;
  logic              w_r_ok;
  logic              w_pick_r;
  logic [SZ_W-1:0]   w_c;
  logic [DATA_W-1:0] w_child;
  logic [SZ_W-1:0]   w_cl;
  logic              w_up_move;
  logic              w_dn_move;

  // The moving key arrives straight from RAM the cycle after POP_RDL's read.
  assign w_cur     = r_cur_pend ? mem_rdata : r_cur;
  assign w_par     = (r_hole - SZ_W'(1)) >> 1;
  assign w_l       = (r_hole << 1) + SZ_W'(1);
  assign w_r       = w_l + SZ_W'(1);
  assign w_r_ok    = (w_r < r_size);
  assign w_pick_r  = w_r_ok && (mem_rdata < r_lval);
  assign w_c       = w_pick_r ? w_r : w_l;
  assign w_child   = w_pick_r ? mem_rdata : r_lval;
  assign w_cl      = (w_c << 1) + SZ_W'(1);
  assign w_up_move = (mem_rdata > w_cur);
  assign w_dn_move = (w_child < w_cur);

  assign cmd_rdy   = r_cmd_rdy;
  assign rsp_v     = r_rsp_v;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_vrd1  = r_rsp_vrd1;
  assign rsp_vrd2  = r_rsp_vrd2;
  assign heap_size = r_size;

  // RAM port: the write-back of a moved key uses the data read in the same state.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_UP_RD: begin
        mem_en   = 1'b1;
        mem_addr = ADDR_W'(w_par);
      end
      S_UP_CMP: if (w_up_move) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(r_hole);
        mem_wdata = mem_rdata;
      end
      S_POP_RD0: mem_en = 1'b1;
      S_POP_RDL: if ((r_op == HEAP_POP) && (r_size > SZ_W'(1))) begin
        mem_en   = 1'b1;
        mem_addr = ADDR_W'(r_size - SZ_W'(1));
      end
      S_DN_RDL: begin
        mem_en   = 1'b1;
        mem_addr = ADDR_W'(w_l);
      end
      S_DN_RDR: if (w_r_ok) begin
        mem_en   = 1'b1;
        mem_addr = ADDR_W'(w_r);
      end
      S_DN_CMP: if (w_dn_move) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(r_hole);
        mem_wdata = w_child;
      end
      S_WR_FIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(r_hole);
        mem_wdata = w_cur;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= HEAP_PUSH;
      r_size     <= '0;
      r_hole     <= '0;
      r_cur      <= '0;
      r_cur_pend <= 1'b0;
      r_lval     <= '0;
      r_cmd_rdy  <= 1'b0;
      r_rsp_v    <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_rd   <= '0;
      r_rsp_vrd1 <= '0;
      r_rsp_vrd2 <= '0;
    end else begin
      r_cur      <= w_cur;
      r_cur_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_rdy <= 1'b1;
          if (cmd_v && r_cmd_rdy) begin
            r_cmd_rdy  <= 1'b0;
            r_op       <= heap_op_e'(cmd_op);
            r_rsp_rd   <= cmd_rd;
            r_rsp_vrd1 <= cmd_vrd1;
            r_rsp_vrd2 <= cmd_vrd2;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            case (heap_op_e'(cmd_op))
              HEAP_PUSH: begin
                if (r_size == SZ_W'(DEPTH)) begin
                  r_rsp_err <= 1'b1;
                  r_rsp_v   <= 1'b1;
                  r_state   <= S_RESP;
                end else begin
                  r_hole  <= r_size;
                  r_cur   <= cmd_data;
                  r_size  <= r_size + SZ_W'(1);
                  r_state <= (r_size == '0) ? S_WR_FIN : S_UP_RD;
                end
              end
              HEAP_POP, HEAP_PEEK: begin
                if (r_size == '0) begin
                  r_rsp_err <= 1'b1;
                  r_rsp_v   <= 1'b1;
                  r_state   <= S_RESP;
                end else begin
                  r_state <= S_POP_RD0;
                end
              end
              default: begin
                r_size  <= '0;
                r_rsp_v <= 1'b1;
                r_state <= S_RESP;
              end
            endcase
          end
        end
        S_UP_RD: r_state <= S_UP_CMP;
        S_UP_CMP: begin
          if (w_up_move) begin
            r_hole  <= w_par;
            r_state <= (w_par == '0) ? S_WR_FIN : S_UP_RD;
          end else begin
            r_state <= S_WR_FIN;
          end
        end
        S_POP_RD0: r_state <= S_POP_RDL;
        S_POP_RDL: begin
          r_rsp_data <= mem_rdata;
          if ((r_op == HEAP_PEEK) || (r_size == SZ_W'(1))) begin
            if (r_op == HEAP_POP) r_size <= '0;
            r_rsp_v <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_size     <= r_size - SZ_W'(1);
            r_hole     <= '0;
            r_cur_pend <= 1'b1;
            r_state    <= (r_size == SZ_W'(2)) ? S_WR_FIN : S_DN_RDL;
          end
        end
        S_DN_RDL: r_state <= S_DN_RDR;
        S_DN_RDR: begin
          r_lval  <= mem_rdata;
          r_state <= S_DN_CMP;
        end
        S_DN_CMP: begin
          if (w_dn_move) begin
            r_hole  <= w_c;
            r_state <= (w_cl < r_size) ? S_DN_RDL : S_WR_FIN;
          end else begin
            r_state <= S_WR_FIN;
          end
        end
        S_WR_FIN: begin
          r_rsp_v <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_rdy) begin
            r_rsp_v   <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
